// File: rtl/i2c_control_unit.sv
// Single-byte I2C master sequencer driving the data unit's control inputs.
// Optional macro I2C_CTRL_NACK_ABORT_EN: a NACK jumps straight to STOP.
module i2c_control_unit (
  input  logic        clock,
  input  logic        Reset,
  input  logic        Go,
  input  logic [6:0]  SlaveAddress,
  input  logic        RW,
  input  logic [7:0]  WriteData,
  input  logic [19:0] BaudRate,
  input  logic [29:0] ClockFrequency,
  input  logic        SDA,
  output logic        SCL,
  output logic [7:0]  SentData,
  output logic        WriteLoad,
  output logic        ReadorWrite,
  output logic        ShiftorHold,
  output logic        Select,
  output logic        StartStopAck,
  output logic        Busy,
  output logic        Done,
  output logic        AckError
);

`ifdef I2C_CTRL_NACK_ABORT_EN
  localparam logic AbortEn = 1'b1;
`else
  localparam logic AbortEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    sIdle, sStart, sAddr, sAck1, sData, sAck2, sStop, sDone
  } stateT;

  stateT       state, nState;
  logic [1:0]  quarter, nQuarter;
  logic [2:0]  bitCnt, nBitCnt;
  logic [30:0] acc, nAcc, sum;
  logic [6:0]  addrR, nAddr;
  logic        rwR, nRw;
  logic [7:0]  dataR, nData;
  logic [19:0] baudR, nBaud;
  logic [29:0] cfR, nCf;
  logic [7:0]  nSent;
  logic        nLoad, nShift, nAckErr;
  logic        nScl, nSel, nSsa, nRow, nBusy, nDone;
  logic        qtick, goOk, accept;

  assign sum    = acc + {9'd0, baudR, 2'b00};
  assign qtick  = Busy && (sum >= {1'b0, cfR});
  assign goOk   = (BaudRate != 20'd0) &&
                  ({2'b00, ClockFrequency} >= {10'd0, BaudRate, 2'b00});
  assign accept = (state == sIdle) && Go && goOk;

  // State, accumulator, latched request and registered outputs
  always_ff @(posedge clock) begin
    if (Reset) begin
      state        <= sIdle;
      quarter      <= 2'd0;
      bitCnt       <= 3'd0;
      acc          <= '0;
      addrR        <= '0;
      rwR          <= 1'b0;
      dataR        <= '0;
      baudR        <= '0;
      cfR          <= '0;
      SentData     <= 8'h00;
      WriteLoad    <= 1'b0;
      ShiftorHold  <= 1'b0;
      AckError     <= 1'b0;
      SCL          <= 1'b1;
      Select       <= 1'b0;
      StartStopAck <= 1'b1;
      ReadorWrite  <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
    end else begin
      state        <= nState;
      quarter      <= nQuarter;
      bitCnt       <= nBitCnt;
      acc          <= nAcc;
      addrR        <= nAddr;
      rwR          <= nRw;
      dataR        <= nData;
      baudR        <= nBaud;
      cfR          <= nCf;
      SentData     <= nSent;
      WriteLoad    <= nLoad;
      ShiftorHold  <= nShift;
      AckError     <= nAckErr;
      SCL          <= nScl;
      Select       <= nSel;
      StartStopAck <= nSsa;
      ReadorWrite  <= nRow;
      Busy         <= nBusy;
      Done         <= nDone;
    end
  end

  // Next state on quarter ticks, then outputs decoded from the next state
  always_comb begin
    nState   = state;
    nQuarter = quarter;
    nBitCnt  = bitCnt;
    nAcc     = acc;
    nAddr    = addrR;
    nRw      = rwR;
    nData    = dataR;
    nBaud    = baudR;
    nCf      = cfR;
    nSent    = SentData;
    nLoad    = 1'b0;
    nShift   = 1'b0;
    nAckErr  = AckError;
    nScl     = 1'b1;
    nSel     = 1'b0;
    nSsa     = 1'b1;
    nRow     = 1'b0;

    if (Busy) begin
      nAcc = qtick ? (sum - {1'b0, cfR}) : sum;
    end

    case (state)
      sIdle: begin
        if (accept) begin
          nState   = sStart;
          nQuarter = 2'd0;
          nBitCnt  = 3'd0;
          nAcc     = '0;
          nAddr    = SlaveAddress;
          nRw      = RW;
          nData    = WriteData;
          nBaud    = BaudRate;
          nCf      = ClockFrequency;
          nAckErr  = 1'b0;
        end
      end
      sDone: nState = sIdle;
      default: begin
        if (qtick) begin
          nQuarter = quarter + 2'd1;
          case (state)
            sStart: begin
              if (quarter == 2'd2) begin
                nSent = {addrR, rwR};
                nLoad = 1'b1;
              end
              if (quarter == 2'd3) begin
                nState  = sAddr;
                nBitCnt = 3'd0;
              end
            end
            sAddr: begin
              if (quarter == 2'd3) begin
                if (bitCnt == 3'd7) begin
                  nState = sAck1;
                end else begin
                  nShift  = 1'b1;
                  nBitCnt = bitCnt + 3'd1;
                end
              end
            end
            sAck1: begin
              if (quarter == 2'd2) begin
                if (SDA) nAckErr = 1'b1;
                if (!rwR && !(AbortEn && SDA)) begin
                  nSent = dataR;
                  nLoad = 1'b1;
                end
              end
              if (quarter == 2'd3) begin
                nBitCnt = 3'd0;
                nState  = (AbortEn && AckError) ? sStop : sData;
              end
            end
            sData: begin
              if (rwR && quarter == 2'd2) nShift = 1'b1;
              if (quarter == 2'd3) begin
                if (bitCnt == 3'd7) begin
                  nState = sAck2;
                end else begin
                  nShift  = !rwR;
                  nBitCnt = bitCnt + 3'd1;
                end
              end
            end
            sAck2: begin
              if (quarter == 2'd2 && !rwR && SDA) nAckErr = 1'b1;
              if (quarter == 2'd3) nState = sStop;
            end
            sStop: begin
              if (quarter == 2'd3) nState = sDone;
            end
            default: ;
          endcase
        end
      end
    endcase

    case (nState)
      sStart: begin
        nRow = 1'b1;
        nSsa = ~nQuarter[1];
      end
      sAddr: begin
        nScl = nQuarter[1];
        nSel = 1'b1;
        nRow = 1'b1;
      end
      sAck1: nScl = nQuarter[1];
      sData: begin
        nScl = nQuarter[1];
        nSel = !nRw;
        nRow = !nRw;
      end
      sAck2: begin
        nScl = nQuarter[1];
        nRow = nRw;
      end
      sStop: begin
        nScl = nQuarter[1];
        nRow = 1'b1;
        nSsa = (nQuarter == 2'd3);
      end
      default: ;
    endcase

    nBusy = (nState != sIdle) && (nState != sDone);
    nDone = (nState == sDone);
  end

endmodule

// File: tb/tb_i2c_control_unit.sv
// Bench for i2c_control_unit: table, random and corner-case frames
// compared cycle by cycle against a slot/quarter timeline model.
module tb_i2c_control_unit;

`ifdef I2C_CTRL_NACK_ABORT_EN
  localparam bit Abort = 1'b1;
`else
  localparam bit Abort = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        Reset, Go, RW, SDA;
  logic [6:0]  SlaveAddress;
  logic [7:0]  WriteData;
  logic [19:0] BaudRate;
  logic [29:0] ClockFrequency;
  logic        SCL, WriteLoad, ReadorWrite, ShiftorHold, Select;
  logic        StartStopAck, Busy, Done, AckError;
  logic [7:0]  SentData;

  int          nChecks = 0;
  int          nFails = 0;
  logic [7:0]  expSent;

  i2c_control_unit dut (
    .clock(clock), .Reset(Reset), .Go(Go),
    .SlaveAddress(SlaveAddress), .RW(RW), .WriteData(WriteData),
    .BaudRate(BaudRate), .ClockFrequency(ClockFrequency), .SDA(SDA),
    .SCL(SCL), .SentData(SentData), .WriteLoad(WriteLoad),
    .ReadorWrite(ReadorWrite), .ShiftorHold(ShiftorHold),
    .Select(Select), .StartStopAck(StartStopAck),
    .Busy(Busy), .Done(Done), .AckError(AckError)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    int         baud;
    int         cf;
    logic       nack1;
    logic       nack2;
    int         expDone;
    logic       expErr;
  } vecT;

  vecT vecs[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] obs();
    return {SCL, Select, StartStopAck, ReadorWrite, Busy, Done,
            WriteLoad, ShiftorHold, AckError, SentData};
  endfunction

  // {SCL, Select, StartStopAck, ReadorWrite} by frame slot and quarter
  function automatic logic [3:0] busOf(int slot, int q, logic r, bit cut);
    logic s, lo, q3;
    s  = (q >= 2);
    lo = (q < 2);
    q3 = (q == 3);
    if (slot == 0) return {1'b1, 1'b0, lo, 1'b1};
    if (slot <= 8) return {s, 3'b111};
    if (slot == 9) return {s, 3'b010};
    if (cut || slot >= 19) return {s, 1'b0, q3, 1'b1};
    if (slot <= 17) return r ? {s, 3'b010} : {s, 3'b111};
    return r ? {s, 3'b011} : {s, 3'b010};
  endfunction

  task automatic runTxn(input logic [6:0] a, input logic r,
                        input logic [7:0] d, input int b, input int f,
                        input logic k1, input logic k2, input bit hold,
                        input int stopAt, output int doneC,
                        output logic errOut);
    int n, prevN, total, slot, q, p, ps, pq;
    bit cut, isNew;
    logic [3:0] bus;
    logic wl, sh, err;
    logic [16:0] expV;
    cut    = Abort && k1;
    total  = cut ? 44 : 80;
    doneC  = -1;
    errOut = 1'b0;
    @(negedge clock);
    SlaveAddress   = a;
    RW             = r;
    WriteData      = d;
    BaudRate       = b[19:0];
    ClockFrequency = f[29:0];
    Go             = 1'b1;
    @(posedge clock);
    prevN = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clock);
      if (!hold) Go = 1'b0;
      if (c == stopAt) return;
      n     = int'((longint'(c) * 4 * b) / f);
      isNew = (c > 0) && (n != prevN);
      prevN = n;
      slot  = n / 4;
      q     = n % 4;
      p     = n - 1;
      ps    = p / 4;
      pq    = p % 4;
      wl = isNew && (n == 3 || (n == 39 && !r && !cut));
      if (wl) expSent = (n == 3) ? {a, r} : d;
      sh = isNew && ((ps >= 1 && ps <= 7 && pq == 3) ||
           (!cut && !r && ps >= 10 && ps <= 16 && pq == 3) ||
           (!cut && r && ps >= 10 && ps <= 17 && pq == 2));
      err = (n >= 39 && k1) || (!r && !cut && n >= 75 && k2);
      if (n < total) begin
        bus  = busOf(slot, q, r, cut);
        expV = {bus, 1'b1, 1'b0, wl, sh, err, expSent};
        check($sformatf("frame c%0d", c), obs(), expV);
        if (slot == 9) SDA = k1;
        else if (slot == 18 && !cut) SDA = k2;
        else SDA = 1'($urandom % 2);
      end else begin
        expV = {4'b1010, 1'b0, 1'b1, 2'b00, err, expSent};
        check($sformatf("done c%0d", c), obs(), expV);
        doneC  = c;
        errOut = AckError;
        @(negedge clock);
        expV = {4'b1010, 1'b0, 1'b0, 2'b00, err, expSent};
        check("post-done idle", obs(), expV);
        if (hold) begin
          @(negedge clock);
          check("held Go re-accepted", {Busy, AckError}, 2'b10);
        end
        return;
      end
    end
    nChecks++;
    nFails++;
    $display("FAIL frame budget: no Done within cycle limit");
  endtask

  initial begin
    int   dc;
    logic er;
    vecs[0] = '{7'h50, 1'b0, 8'hCA, 1, 8, 1'b0, 1'b0, 160, 1'b0};
    vecs[1] = '{7'h21, 1'b1, 8'h5A, 1, 8, 1'b0, 1'b0, 160, 1'b0};
    vecs[2] = '{7'h50, 1'b0, 8'hCA, 1, 8, 1'b1, 1'b0,
                Abort ? 88 : 160, 1'b1};
    vecs[3] = '{7'h3C, 1'b0, 8'h81, 2, 12, 1'b0, 1'b0, 120, 1'b0};
    vecs[4] = '{7'h7F, 1'b0, 8'hFF, 1, 4, 1'b0, 1'b1, 80, 1'b1};
    vecs[5] = '{7'h12, 1'b1, 8'h00, 3, 40, 1'b1, 1'b0,
                Abort ? 147 : 267, 1'b1};

    Reset = 1'b1; Go = 1'b0; SDA = 1'b1; RW = 1'b0;
    SlaveAddress = '0; WriteData = '0;
    BaudRate = '0; ClockFrequency = '0;
    expSent = 8'h00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset state", obs(), {4'b1010, 5'b00000, 8'h00});
    Reset = 1'b0;

    BaudRate = 20'd0; ClockFrequency = 30'd8; Go = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("reject baud 0", Busy, 1'b0);
    end
    BaudRate = 20'd3; ClockFrequency = 30'd11;
    repeat (3) begin
      @(negedge clock);
      check("reject slow clock", Busy, 1'b0);
    end
    Go = 1'b0;

    for (int i = 0; i < 6; i++) begin
      runTxn(vecs[i].addr, vecs[i].rw, vecs[i].data, vecs[i].baud,
             vecs[i].cf, vecs[i].nack1, vecs[i].nack2, 1'b0, -1, dc, er);
      check($sformatf("vec%0d done cycle", i), dc, vecs[i].expDone);
      check($sformatf("vec%0d AckError", i), er, vecs[i].expErr);
    end

    for (int i = 0; i < 6; i++) begin
      int b, f;
      b = int'($urandom_range(1, 4));
      f = 4 * b + int'($urandom_range(0, 20));
      runTxn(7'($urandom), 1'($urandom), 8'($urandom), b, f,
             1'($urandom), 1'($urandom), 1'b0, -1, dc, er);
    end

    runTxn(7'h55, 1'b0, 8'h3C, 1, 8, 1'b0, 1'b0, 1'b0, 32, dc, er);
    Reset = 1'b1;
    @(negedge clock);
    check("reset mid-frame",
          {SCL, ReadorWrite, Busy, Done, AckError}, 5'b10000);
    Reset = 1'b0;
    expSent = 8'h00;
    repeat (4) begin
      @(negedge clock);
      check("idle after reset", {Busy, Done}, 2'b00);
    end

    runTxn(7'h0F, 1'b0, 8'hA5, 1, 4, 1'b1, 1'b0, 1'b1, -1, dc, er);
    check("held Go first done", dc, 80);
    Go = 1'b0;
    Reset = 1'b1;
    @(negedge clock);
    Reset = 1'b0;
    expSent = 8'h00;
    @(negedge clock);
    check("final idle", obs(), {4'b1010, 5'b00000, 8'h00});

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/i2c_control_unit.md
# i2c_control_unit

- Single-byte I2C master sequencer that drives the control inputs of the I2C data unit: `WriteLoad`, `ReadorWrite`, `ShiftorHold`, `Select`, `StartStopAck` and `SentData`.
- Generates SCL from `BaudRate`/`ClockFrequency`, frames START, address+R/W, ACK, one data byte, ACK/NACK and STOP, and samples SDA for acknowledges.
- Sits directly upstream of the data unit; the data unit owns the SDA driver and shift register.

## Interface
- No parameters; byte length fixed at 8.
- `clock` in 1: single system clock. One clock; reset is synchronous and active-high.
- `Reset` in 1: synchronous, active-high.
- `Go` in 1: start a transaction; sampled only in IDLE.
- `SlaveAddress` in 7: target address, latched on accepted `Go`.
- `RW` in 1: 0 = write, 1 = read; latched on accepted `Go`.
- `WriteData` in 8: byte to send, latched on accepted `Go`.
- `BaudRate` in 20: SCL rate in Hz, latched on accepted `Go`.
- `ClockFrequency` in 30: `clock` rate in Hz, latched on accepted `Go`.
- `SDA` in 1: sampled bus line, used for the ACK bit only.
- `SCL` out 1: I2C clock (push-pull).
- `SentData` out 8: byte presented to the data unit.
- `WriteLoad` out 1: one-cycle pulse that loads `SentData` into the data unit.
- `ReadorWrite` out 1: 1 = data unit drives SDA; 0 = SDA released.
- `ShiftorHold` out 1: one-cycle pulse that shifts the data unit one bit.
- `Select` out 1: 1 = SDA from shift-register MSB; 0 = SDA from `StartStopAck`.
- `StartStopAck` out 1: level driven on SDA when `Select` = 0.
- `Busy` out 1: high from the cycle after an accepted `Go` until `Done`.
- `Done` out 1: one-cycle pulse at the end of a transaction.
- `AckError` out 1: sticky NACK flag; cleared on the next accepted `Go`.

## Operation
- **Quarter tick generator**
  - 31-bit accumulator adds `4*BaudRate` (22 bits, zero-extended) each cycle while `Busy`.
  - When the sum is ≥ `ClockFrequency`, it subtracts `ClockFrequency` and asserts `qtick` for that cycle.
  - The accumulator is cleared on accepted `Go`.
- **Bit slot**
  - Each bit slot is 4 quarter ticks, Q0..Q3.
  - SCL is low in Q0–Q1 and high in Q2–Q3.
  - SDA changes only at Q0; SDA is sampled on the qtick that ends Q2.
- **Go acceptance**
  - `Go` is ignored when `BaudRate` == 0 or `ClockFrequency` < `4*BaudRate`.
  - `Go` is ignored while `Busy`.
- **IDLE**
  - SCL = 1, `Select` = 0, `StartStopAck` = 1, `ReadorWrite` = 0.
- **START**
  - SCL held high for all 4 quarters; `Select` = 0, `ReadorWrite` = 1.
  - `StartStopAck` = 1 in Q0–Q1 and 0 in Q2–Q3.
- **ADDR**
  - On entry: `SentData` = {`SlaveAddress`, `RW`} and `WriteLoad` pulses once.
  - `Select` = 1, `ReadorWrite` = 1 for 8 slots.
  - `ShiftorHold` pulses on the qtick ending Q3 of slots 0–6.
- **ACK1**
  - `ReadorWrite` = 0; SDA sampled at end of Q2; 1 = NACK.
- **DATA, write (`RW` = 0)**
  - On entry: `SentData` = `WriteData`, `WriteLoad` pulses, then shifted as in ADDR.
- **DATA, read (`RW` = 1)**
  - `ReadorWrite` = 0; `ShiftorHold` pulses on the qtick ending Q2 of each of the 8 slots.
- **ACK2**
  - Write: slave ACK sampled as in ACK1.
  - Read: master NACK, i.e. `Select` = 0, `ReadorWrite` = 1, `StartStopAck` = 1.
- **STOP**
  - `Select` = 0, `ReadorWrite` = 1.
  - SCL low in Q0–Q1 and high in Q2–Q3.
  - `StartStopAck` = 0 in Q0–Q2 and 1 in Q3.
- **DONE**
  - `Done` pulses for one cycle, then the block returns to IDLE.
- **State order**
  - IDLE → START → ADDR → ACK1 → DATA → ACK2 → STOP → DONE → IDLE.
- A NACK sets `AckError`; the resulting flow is set by the Configuration section.

## Timing
- **Reset values:**
  - `SCL` = 1, `StartStopAck` = 1.
  - `SentData` = 0.
  - `WriteLoad`, `ReadorWrite`, `ShiftorHold`, `Select`, `Busy`, `Done`, `AckError` = 0.
  - State = IDLE, accumulator = 0.
- **Latency:**
  - `Busy` rises 1 cycle after the `Go` cycle.
  - Full transaction = 20 bit slots = 80 qticks.
  - `Done` is asserted in the cycle after the final STOP qtick; `Busy` falls in the same cycle.
- **Registered outputs:** all outputs are registered. The `WriteLoad` pulse precedes the first Q0 of its byte by at least 1 cycle.
- **Reset mid-transaction:** the block returns to IDLE next cycle with no STOP generated. `AckError` clears.
- **`Go` held high:** re-accepted only in the cycle after `Done`.

## Configuration
- Macro: `I2C_CTRL_NACK_ABORT_EN`.
- **Defined:** a NACK at ACK1 or at write-ACK2 sets `AckError` and jumps directly to STOP. DATA is skipped when the NACK is at ACK1. `Done` still pulses.
- **Undefined:** ACK is sampled and `AckError` is set on NACK, but the full frame always completes.

## Test plan
- **Write frame**
  - Stimulus: `BaudRate` = 1, `ClockFrequency` = 8, `SlaveAddress` = 7'h50, `RW` = 0, `WriteData` = 8'hCA, bench drives SDA = 0 at both ACKs.
  - Required response:
    - qtick every 2 cycles.
    - `WriteLoad` pulses with `SentData` = 8'hA0, then with 8'hCA.
    - 7 `ShiftorHold` pulses per byte.
    - `Done` 160 cycles after `Busy` rises; `AckError` = 0.
- **Read frame**
  - Stimulus: `RW` = 1, `SlaveAddress` = 7'h21.
  - Required response: `SentData` = 8'h43; 8 `ShiftorHold` pulses with `ReadorWrite` = 0; ACK2 drives `StartStopAck` = 1 with `Select` = 0.
- **Address NACK**
  - Stimulus: SDA = 1 at ACK1.
  - Required response with the macro defined: STOP follows ACK1 directly; `Done` after 11 slots (88 cycles); `AckError` = 1.
  - Required response with the macro undefined: full 160 cycles; `AckError` = 1.
- **Fractional rate**
  - Stimulus: `BaudRate` = 2, `ClockFrequency` = 12.
  - Required response: qticks follow the repeating cycle gaps 1, 2 (2 ticks per 3 cycles); SCL edges fall only on qtick cycles.
- **Rejected Go and reset mid-transaction**
  - Stimulus: `BaudRate` = 0 with `Go`.
  - Required response: `Busy` stays 0.
  - Stimulus: `Reset` asserted in ADDR slot 3.
  - Required response: next cycle SCL = 1, `ReadorWrite` = 0, `Busy` = 0, `Done` not pulsed.
